// File: rtl/cam_pkg.sv
// Shared constants, FSM state encoding and response payload for the CAM
// lookup-or-insert controller.
package cam_pkg;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned KEY_W = 32;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = IDX_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_WAIT,
    ST_RESOLVE,
    ST_WRITE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic             hit;
    logic             new_entry;
    logic             full;
    logic [IDX_W-1:0] index;
  } rsp_t;

  // Number of live entries in an entry-valid bitmap.
  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sum = sum + OCC_W'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/cam_free_finder.sv
// Lowest-numbered free entry in the entry-valid bitmap, plus an any-free flag.
module cam_free_finder
  import cam_pkg::*;
(
  input  logic [DEPTH-1:0] bitmap,
  output logic [IDX_W-1:0] free_idx_c,
  output logic             any_free_c
);

  // Scan downward so the lowest clear bit is the last one to assign.
  always_comb begin
    free_idx_c = '0;
    any_free_c = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!bitmap[i]) begin
        free_idx_c = IDX_W'(i);
        any_free_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_alloc_ctrl.sv
// Lookup-or-insert controller in front of a 32x32 CAM; owns the entry-valid
// bitmap since the CAM itself cannot invalidate entries.
module cam_alloc_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned CAM_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [KEY_W-1:0] req_key_i,
  input  logic             req_insert_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_hit_o,
  output logic             rsp_new_o,
  output logic             rsp_full_o,
  output logic [IDX_W-1:0] rsp_index_o,
  input  logic             inv_valid_i,
  input  logic [IDX_W-1:0] inv_index_i,
  output logic [OCC_W-1:0] occupancy_o,
  output logic             cam_read_enable_o,
  output logic [IDX_W-1:0] cam_read_index_o,
  output logic             cam_write_enable_o,
  output logic [IDX_W-1:0] cam_write_index_o,
  output logic [KEY_W-1:0] cam_write_data_o,
  output logic             cam_search_enable_o,
  output logic [KEY_W-1:0] cam_search_data_o,
  input  logic             cam_search_valid_i,
  input  logic [IDX_W-1:0] cam_search_index_i
);

  localparam int unsigned CNT_W = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q;
  logic             insert_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             hit_v_q;
  logic [IDX_W-1:0] hit_idx_q;
  logic [DEPTH-1:0] bitmap_q, bitmap_d;
  rsp_t             rsp_q, rsp_d;
  logic             set_en;
  logic [IDX_W-1:0] set_idx;

  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             search_en_q;
  logic             write_en_q;
  logic [IDX_W-1:0] write_idx_q;
  logic [OCC_W-1:0] occ_q;

  logic [IDX_W-1:0] free_idx_c;
  logic             any_free_c;

  cam_free_finder u_free_finder (
    .bitmap     (bitmap_q),
    .free_idx_c (free_idx_c),
    .any_free_c (any_free_c)
  );

  // Next-state and response decision.
  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    set_en  = 1'b0;
    set_idx = hit_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == CNT_W'(CAM_LAT - 1)) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        rsp_d   = '0;
        state_d = ST_RESP;
        if (hit_v_q && bitmap_q[hit_idx_q]) begin
          rsp_d.hit   = 1'b1;
          rsp_d.index = hit_idx_q;
        end else if (hit_v_q && insert_q) begin
          // Stale CAM entry for this key: revive it instead of duplicating.
          set_en          = 1'b1;
          rsp_d.new_entry = 1'b1;
          rsp_d.index     = hit_idx_q;
        end else if (insert_q && any_free_c) begin
          state_d = ST_WRITE;
        end else if (insert_q) begin
          rsp_d.full = 1'b1;
        end
      end
      ST_WRITE: begin
        set_en          = 1'b1;
        set_idx         = write_idx_q;
        rsp_d.new_entry = 1'b1;
        rsp_d.index     = write_idx_q;
        state_d         = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Allocation beats invalidation when both target the same entry.
  always_comb begin
    bitmap_d = bitmap_q;
    if (inv_valid_i) bitmap_d[inv_index_i] = 1'b0;
    if (set_en)      bitmap_d[set_idx]     = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      insert_q   <= 1'b0;
      wait_cnt_q <= '0;
      hit_v_q    <= 1'b0;
      hit_idx_q  <= '0;
      bitmap_q   <= '0;
      rsp_q      <= '0;
    end else begin
      state_q    <= state_d;
      bitmap_q   <= bitmap_d;
      rsp_q      <= rsp_d;
      wait_cnt_q <= (state_q == ST_WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
      if (state_q == ST_IDLE && req_valid_i) begin
        key_q    <= req_key_i;
        insert_q <= req_insert_i;
      end
      if (state_q == ST_WAIT && state_d == ST_RESOLVE) begin
        hit_v_q   <= cam_search_valid_i;
        hit_idx_q <= cam_search_index_i;
      end
    end
  end

  // Registered outputs, decoded from the upcoming state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      search_en_q <= 1'b0;
      write_en_q  <= 1'b0;
      write_idx_q <= '0;
      occ_q       <= '0;
    end else begin
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      search_en_q <= (state_d == ST_SEARCH);
      write_en_q  <= (state_d == ST_WRITE);
      occ_q       <= popcount(bitmap_q);
      if (state_q == ST_RESOLVE && state_d == ST_WRITE) write_idx_q <= free_idx_c;
    end
  end

  assign req_ready_o         = req_ready_q;
  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_hit_o           = rsp_q.hit;
  assign rsp_new_o           = rsp_q.new_entry;
  assign rsp_full_o          = rsp_q.full;
  assign rsp_index_o         = rsp_q.index;
  assign occupancy_o         = occ_q;
  assign cam_read_enable_o   = 1'b0;
  assign cam_read_index_o    = '0;
  assign cam_write_enable_o  = write_en_q;
  assign cam_write_index_o   = write_idx_q;
  assign cam_write_data_o    = key_q;
  assign cam_search_enable_o = search_en_q;
  assign cam_search_data_o   = key_q;

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Randomized scoreboard bench for cam_alloc_ctrl with a behavioural CAM and
// a key-table reference model.
module tb_cam_alloc_ctrl;
  import cam_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [KEY_W-1:0] req_key = '0;
  logic             req_insert = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic             rsp_hit, rsp_new, rsp_full;
  logic [IDX_W-1:0] rsp_index;
  logic             inv_valid = 1'b0;
  logic [IDX_W-1:0] inv_index = '0;
  logic [OCC_W-1:0] occupancy;
  logic             cam_rd_en;
  logic [IDX_W-1:0] cam_rd_idx;
  logic             cam_wr_en;
  logic [IDX_W-1:0] cam_wr_idx;
  logic [KEY_W-1:0] cam_wr_data;
  logic             cam_srch_en;
  logic [KEY_W-1:0] cam_srch_data;
  logic             cam_sv = 1'b0;
  logic [IDX_W-1:0] cam_si = '0;

  always #5 clk = ~clk;

  cam_alloc_ctrl #(.CAM_LAT(1)) dut (
    .clk_i               (clk),
    .rst_i               (rst_n),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_key_i           (req_key),
    .req_insert_i        (req_insert),
    .rsp_valid_o         (rsp_valid),
    .rsp_ready_i         (rsp_ready),
    .rsp_hit_o           (rsp_hit),
    .rsp_new_o           (rsp_new),
    .rsp_full_o          (rsp_full),
    .rsp_index_o         (rsp_index),
    .inv_valid_i         (inv_valid),
    .inv_index_i         (inv_index),
    .occupancy_o         (occupancy),
    .cam_read_enable_o   (cam_rd_en),
    .cam_read_index_o    (cam_rd_idx),
    .cam_write_enable_o  (cam_wr_en),
    .cam_write_index_o   (cam_wr_idx),
    .cam_write_data_o    (cam_wr_data),
    .cam_search_enable_o (cam_srch_en),
    .cam_search_data_o   (cam_srch_data),
    .cam_search_valid_i  (cam_sv),
    .cam_search_index_i  (cam_si)
  );

  // Behavioural CAM: one-cycle search, lowest matching index, never cleared.
  logic [KEY_W-1:0] cam_mem  [DEPTH];
  bit               cam_used [DEPTH];

  always @(posedge clk) begin
    if (cam_srch_en) begin
      cam_sv <= 1'b0;
      cam_si <= '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (cam_used[i] && cam_mem[i] == cam_srch_data) begin
          cam_sv <= 1'b1;
          cam_si <= IDX_W'(i);
        end
      end
    end
    if (cam_wr_en) begin
      cam_mem[cam_wr_idx]  <= cam_wr_data;
      cam_used[cam_wr_idx] <= 1'b1;
    end
  end

  // Reference model: what key each slot holds and which slots are live.
  logic [KEY_W-1:0] m_key  [DEPTH];
  bit               m_used [DEPTH];
  bit               m_live [DEPTH];

  typedef struct {
    logic             hit;
    logic             nw;
    logic             full;
    logic [IDX_W-1:0] idx;
    int               lat;
    int               nwr;
    logic [IDX_W-1:0] widx;
    logic [KEY_W-1:0] wdata;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  logic [KEY_W-1:0] cur_key = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int live_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_live[i]);
    return n;
  endfunction

  function automatic exp_t predict(input logic [KEY_W-1:0] key, input logic ins);
    exp_t e;
    int   hi = -1;
    int   fi = -1;
    e.hit = 1'b0; e.nw = 1'b0; e.full = 1'b0; e.idx = '0;
    e.lat = 4; e.nwr = 0; e.widx = '0; e.wdata = '0; e.acc = 0;
    for (int i = 0; i < DEPTH; i++)
      if (hi < 0 && m_used[i] && m_key[i] == key) hi = i;
    if (hi >= 0 && m_live[hi]) begin
      e.hit = 1'b1; e.idx = IDX_W'(hi);
    end else if (hi >= 0 && ins) begin
      m_live[hi] = 1'b1; e.nw = 1'b1; e.idx = IDX_W'(hi);
    end else if (ins) begin
      for (int i = 0; i < DEPTH; i++)
        if (fi < 0 && !m_live[i]) fi = i;
      if (fi >= 0) begin
        m_key[fi] = key; m_used[fi] = 1'b1; m_live[fi] = 1'b1;
        e.nw = 1'b1; e.idx = IDX_W'(fi); e.lat = 5;
        e.nwr = 1; e.widx = IDX_W'(fi); e.wdata = key;
      end else begin
        e.full = 1'b1;
      end
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: check search key, collect writes, score each response.
  bit               mon_active = 1'b0;
  logic [7:0]       snap = '0;
  int               wr_cnt = 0;
  logic [IDX_W-1:0] wr_idx = '0;
  logic [KEY_W-1:0] wr_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cam_srch_en) chk("search_key", 64'(cam_srch_data), 64'(cur_key));
      if (cam_wr_en) begin
        wr_cnt++; wr_idx = cam_wr_idx; wr_data = cam_wr_data;
      end
      if (rsp_valid && !mon_active) begin
        exp_t e;
        mon_active = 1'b1;
        snap = {rsp_hit, rsp_new, rsp_full, rsp_index};
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_rsp: got response with empty scoreboard (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
          chk("rsp_new", 64'(rsp_new), 64'(e.nw));
          chk("rsp_full", 64'(rsp_full), 64'(e.full));
          chk("rsp_index", 64'(rsp_index), 64'(e.idx));
          chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("cam_writes", 64'(wr_cnt), 64'(e.nwr));
          if (e.nwr > 0) begin
            chk("cam_wr_idx", 64'(wr_idx), 64'(e.widx));
            chk("cam_wr_data", 64'(wr_data), 64'(e.wdata));
          end
        end
        wr_cnt = 0;
      end else if (rsp_valid) begin
        chk("rsp_stable", 64'({rsp_hit, rsp_new, rsp_full, rsp_index}), 64'(snap));
      end else begin
        mon_active = 1'b0;
      end
    end
  end

  task automatic do_req(input logic [KEY_W-1:0] key, input logic ins, input int stall);
    exp_t e;
    int   t;
    @(posedge clk); #1;
    req_valid = 1'b1; req_key = key; req_insert = ins; rsp_ready = (stall == 0);
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) chk("req_accept_timeout", 64'(req_ready), 64'(1));
    cur_key = key;
    e = predict(key, ins);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk); #1 req_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!rsp_valid && t < 20);
    if (!rsp_valid) chk("rsp_timeout", 64'(rsp_valid), 64'(1));
    for (int s = 0; s < stall; s++) begin
      chk("stall_req_ready", 64'(req_ready), 64'(0));
      chk("stall_rsp_valid", 64'(rsp_valid), 64'(1));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (rsp_valid && t < 10);
    if (rsp_valid) chk("rsp_drop_timeout", 64'(rsp_valid), 64'(0));
    chk("occupancy", 64'(occupancy), 64'(live_cnt()));
  endtask

  task automatic do_inv(input int idx);
    @(posedge clk); #1;
    inv_valid = 1'b1; inv_index = IDX_W'(idx); m_live[idx] = 1'b0;
    @(posedge clk); #1 inv_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("occupancy_inv", 64'(occupancy), 64'(live_cnt()));
  endtask

  logic [KEY_W-1:0] keys [34];

  initial begin
    int vcnt;
    for (int i = 0; i < DEPTH; i++) begin
      cam_used[i] = 1'b0; m_used[i] = 1'b0; m_live[i] = 1'b0;
      cam_mem[i] = '0; m_key[i] = '0;
    end
    keys[0] = 32'hDEAD_BEEF;
    for (int i = 1; i < 34; i++) keys[i] = 32'hA500_0000 + KEY_W'(i * 7);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'(1));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_occupancy", 64'(occupancy), 64'(0));
    chk("reset_cam_ctl", 64'({cam_wr_en, cam_srch_en, cam_rd_en}), 64'(0));
    chk("cam_read_idx", 64'(cam_rd_idx), 64'(0));

    do_req(32'hDEAD_BEEF, 1'b1, 0);
    do_req(32'hDEAD_BEEF, 1'b0, 0);
    do_req(32'h0000_1234, 1'b0, 0);

    // Fill the remaining entries, then overflow.
    for (int i = 1; i < 32; i++) do_req(keys[i], 1'b1, 0);
    do_req(keys[32], 1'b1, 0);
    chk("occupancy_full", 64'(occupancy), 64'(32));

    // Reclaim a freed key, then allocate the lowest hole.
    do_inv(5);
    do_req(keys[5], 1'b1, 0);
    do_inv(9);
    do_inv(3);
    do_req(keys[33], 1'b1, 0);

    // Hit held in RESP while the client stalls.
    do_req(keys[0], 1'b0, 10);
    do_req(keys[7], 1'b0, 0);

    // Randomized mix of lookups, inserts and invalidates.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 2) do_inv(int'($urandom_range(0, DEPTH - 1)));
      else if ($urandom_range(0, 3) == 0)
        do_req($urandom, 1'(($urandom_range(0, 1))), int'($urandom_range(0, 2)));
      else
        do_req(keys[$urandom_range(0, 33)], 1'(($urandom_range(0, 1))),
               int'($urandom_range(0, 2)));
    end

    // Reset while the request is waiting on the CAM.
    @(posedge clk); #1;
    req_valid = 1'b1; req_key = 32'hDEAD_BEEF; req_insert = 1'b0;
    @(negedge clk);
    cur_key = 32'hDEAD_BEEF;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_live[i] = 1'b0;
    @(negedge clk);
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    rst_n = 1'b1;
    vcnt = 0;
    repeat (8) begin @(negedge clk); vcnt += int'(rsp_valid); end
    chk("rst_no_response", 64'(vcnt), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_occupancy_after", 64'(occupancy), 64'(0));
    do_req(32'hDEAD_BEEF, 1'b0, 0);
    do_req(32'hDEAD_BEEF, 1'b1, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cam_alloc_ctrl.md
Name: cam_alloc_ctrl

Overview:
- Lookup-or-insert controller directly upstream of the 32x32 CAM; drives the CAM's write/search/read inputs and consumes its search outputs.
- Clients issue keyed requests over a valid/ready handshake and receive hit/new/miss/full responses with a CAM index.
- Owns an entry-valid bitmap, because the CAM has no invalidate; the bitmap is the authority on entry liveness.

Parameters:
DEPTH, 32, number of CAM entries
KEY_W, 32, key/data width
IDX_W, 5, index width, $clog2(DEPTH)
CAM_LAT, 1, cycles from search enable to CAM search_valid/index sample point (1..4)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  controller can accept a request
req_key_i  in  KEY_W  lookup key
req_insert_i  in  1  allocate an entry on miss
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_hit_o  out  1  key present and live
rsp_new_o  out  1  entry allocated or reclaimed by this request
rsp_full_o  out  1  insert requested but no free entry
rsp_index_o  out  IDX_W  index for hit/new, else 0
inv_valid_i  in  1  free an entry
inv_index_i  in  IDX_W  entry to free
occupancy_o  out  IDX_W+1  live-entry count
cam_read_enable_o  out  1  tied 0
cam_read_index_o  out  IDX_W  tied 0
cam_write_enable_o  out  1  CAM write strobe
cam_write_index_o  out  IDX_W  CAM write index
cam_write_data_o  out  KEY_W  CAM write data
cam_search_enable_o  out  1  CAM search strobe
cam_search_data_o  out  KEY_W  CAM search key
cam_search_valid_i  in  1  CAM search hit
cam_search_index_i  in  IDX_W  CAM hit index

Behaviour:
- Reset (rst_i low, async): state IDLE; bitmap all 0; all outputs 0 except req_ready_o=1 once out of reset. Mid-operation reset drops the in-flight request with no response. CAM contents are not cleared; the bitmap masks them.
- FSM states: IDLE, SEARCH, WAIT, RESOLVE, WRITE, RESP.
- IDLE: req_ready_o=1. On req_valid_i&&req_ready_o, latch key/insert and go to SEARCH. req_ready_o=0 in all other states; one request in flight.
- SEARCH: cam_search_enable_o=1 for exactly one cycle with cam_search_data_o = latched key.
- WAIT: count CAM_LAT cycles, then sample cam_search_valid_i/index into registers and go to RESOLVE.
- RESOLVE, decided in priority order:
  - Hit with live bit: hit=1, index=hit idx.
  - Hit with freed bit and insert: set bit, new=1, index=hit idx, no write (stale entry reclaimed, prevents duplicate keys).
  - Hit with freed bit and no insert: miss.
  - Miss with insert and a free entry: go to WRITE with alloc index = lowest-numbered free bit.
  - Miss with insert and no free entry: full=1.
  - Miss without insert: all flags 0.
  - All non-WRITE outcomes go to RESP.
- WRITE: cam_write_enable_o=1 for one cycle, index=alloc, data=key; set bit; new=1, index=alloc; go to RESP.
- RESP: rsp_valid_o=1; rsp fields stable until rsp_ready_i; on accept go to IDLE.
  - Minimum gap from a write to the next search is 2 cycles, which satisfies CAM write-to-search visibility.
- Request latency with CAM_LAT=1 and rsp_ready_i held 1: hit/miss rsp_valid_o 4 cycles after accept; insert 5 cycles.
- Invalidate: any cycle, clears the bit on the next edge. If it hits the same bit being set that cycle, set wins. Invalidating an already-free entry is a no-op. A hit response already in RESP is not retracted.
- occupancy_o: registered popcount of bitmap; updates the cycle after a bit change; range 0..DEPTH.
- Unused CAM read port is driven 0.

Decomposition:
- Package cam_pkg: DEPTH, KEY_W, IDX_W constants; state_e enum; rsp_t struct {hit,new,full,index}.
- One sub-module, cam_free_finder: combinational lowest-free-index priority encoder plus any_free flag over the bitmap.

Test Plan:
- Reset, then insert key 0xDEAD_BEEF -> single CAM write at index 0; rsp new=1 index=0; occupancy 1; rsp_valid 5 cycles after accept.
- Lookup 0xDEAD_BEEF without insert -> hit=1 index=0, no CAM write; lookup 0x1234 without insert -> all flags 0, index 0.
- Insert 32 distinct keys, then insert a 33rd -> indices 0..31 in order; 33rd gives full=1, no write; occupancy 32.
- Invalidate index 5 (key K5), then insert K5 -> new=1 index=5, no CAM write (reclaim); insert new key -> lowest free index.
- Hold rsp_ready_i low 10 cycles with a hit pending -> rsp fields stable, req_ready_o=0 throughout; accept -> IDLE, next request taken.
- Assert rst_i low during WAIT -> no response; bitmap cleared; occupancy 0; prior key lookup misses.
